// File: rtl/buffer_burst_reader.sv
// buffer_burst_reader
//   Requests read access to a shared buffer and, once the arbiter grants it,
//   reads up to BURST_LEN consecutive words starting from a sampled base
//   address. A request that is not granted within TIMEOUT cycles is abandoned
//   and flagged. All outputs are registered.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   enable       : writer-side read request (level)
//   base_addr    : burst start address, sampled when a request starts
//   read_allowed : high while the burst is being read
//   ack_read     : grant acknowledge from the buffer arbiter
//   rq_read      : request to the buffer arbiter
//   reading      : buffer-side busy indicator
//   rd_en        : one word is read this cycle
//   rd_addr      : address of the word read while rd_en is high
//   words_read   : word count of the last completed burst
//   done         : one-cycle pulse when a granted burst finishes
//   timeout_err  : one-cycle pulse when a request times out
module buffer_burst_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  read_allowed,
    input  logic                  ack_read,
    output logic                  rq_read,
    output logic                  reading,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]           words_read,
    output logic                  done,
    output logic                  timeout_err
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] REQUESTING = 2'd1;
    localparam logic [1:0] READING    = 2'd2;
    localparam logic [1:0] ENDING     = 2'd3;

    localparam int              WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value the wait counter holds on the cycle whose increment reaches TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [15:0]     BURST_MAX  = 16'(BURST_LEN);

    logic [1:0]            state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [15:0]           word_cnt;
    // Address of the next word to read; rd_addr keeps the last one presented.
    logic [ADDR_WIDTH-1:0] next_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            word_cnt     <= '0;
            next_addr    <= '0;
            rq_read      <= 1'b0;
            reading      <= 1'b0;
            read_allowed <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            words_read   <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            rd_en       <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= REQUESTING;
                        rq_read   <= 1'b1;
                        rd_addr   <= base_addr;
                        next_addr <= base_addr;
                        wait_cnt  <= '0;
                    end
                end

                REQUESTING: begin
                    // Grant beats withdrawal, which beats timeout.
                    if (ack_read) begin
                        state        <= READING;
                        rq_read      <= 1'b0;
                        reading      <= 1'b1;
                        read_allowed <= 1'b1;
                        word_cnt     <= '0;
                    end else if (!enable) begin
                        state   <= IDLE;
                        rq_read <= 1'b0;
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        state       <= IDLE;
                        rq_read     <= 1'b0;
                        timeout_err <= 1'b1;
                        wait_cnt    <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                READING: begin
                    if (enable && (word_cnt < BURST_MAX)) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= next_addr;
                        next_addr <= next_addr + 1'b1;
                        word_cnt  <= word_cnt + 16'd1;
                    end else begin
                        state        <= ENDING;
                        reading      <= 1'b0;
                        read_allowed <= 1'b0;
                    end
                end

                default: begin
                    // ENDING: hold until the arbiter releases its grant.
                    if (!ack_read) begin
                        state      <= IDLE;
                        words_read <= word_cnt;
                        done       <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/buffer_burst_reader.md
BUFFER_BURST_READER -- requirements
Module: buffer_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning read address width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 64, meaning max words read per grant (1..2^16-1).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for ack_read; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  writer-side request to read; level-sensitive.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  start address, sampled on IDLE->REQUESTING.
REQ-008 SHALL have port read_allowed  output  1  high while in READING.
REQ-009 SHALL have port ack_read  input  1  buffer grant acknowledge.
REQ-010 SHALL have port rq_read  output  1  request to buffer arbiter.
REQ-011 SHALL have port reading  output  1  buffer-side busy indicator.
REQ-012 SHALL have port rd_en  output  1  one word read this cycle.
REQ-013 SHALL have port rd_addr  output  ADDR_WIDTH  address of word read when rd_en high.
REQ-014 SHALL have port words_read  output  16  words read in last completed burst.
REQ-015 SHALL have port done  output  1  one-cycle pulse on ENDING->IDLE.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse on request timeout.

Function
REQ-017 SHALL implement states IDLE, REQUESTING, READING, ENDING; all outputs registered.
REQ-018 IDLE: rq_read, reading, read_allowed, rd_en low; enable high -> REQUESTING, rq_read=1 next cycle, rd_addr<=base_addr, wait counter cleared.
REQ-019 REQUESTING: rq_read held high; wait counter +1 per cycle without ack_read.
REQ-020 REQUESTING, ack_read high -> READING next cycle: rq_read=0, reading=1, word counter=0.
REQ-021 REQUESTING, ack_read low and enable low -> IDLE, rq_read=0, no done, no timeout_err (request withdrawn).
REQ-022 REQUESTING, TIMEOUT!=0, wait counter reaches TIMEOUT with ack_read low -> IDLE, rq_read=0, timeout_err pulses 1 cycle.
REQ-023 Priority in REQUESTING same cycle: ack_read > enable-low withdrawal > timeout.
REQ-024 READING: read_allowed=1; rd_en=1 each cycle enable high and word counter < BURST_LEN; first rd_en one cycle after READING entry.
REQ-025 Each rd_en cycle: rd_addr presents current address, then increments by 1 modulo 2^ADDR_WIDTH (wrap from all-ones to 0); word counter +1.
REQ-026 READING exits to ENDING when enable low or word counter == BURST_LEN; on exit read_allowed=0, reading=0, rd_en=0 same edge.
REQ-027 Ack in same cycle as enable drop: enter READING, then ENDING with words_read=0.
REQ-028 ENDING: remain until ack_read low, then -> IDLE, words_read<=word counter, done pulses 1 cycle.
REQ-029 rd_en SHALL never assert outside READING; total rd_en pulses per grant <= BURST_LEN.
REQ-030 Re-entry: enable still high in IDLE after done -> new REQUESTING next cycle, new base_addr sampled.

Reset
REQ-031 reset high SHALL force IDLE immediately, independent of clk, from any state including mid-burst.
REQ-032 Reset values: rq_read=0, reading=0, read_allowed=0, rd_en=0, rd_addr=0, words_read=0, done=0, timeout_err=0, counters=0.
REQ-033 After reset release, first state change occurs no earlier than first rising edge with enable high.

Verification
REQ-034 Full burst: BURST_LEN=4, base_addr=0x10, enable held, ack after 3 cycles -> rd_en 4 pulses, rd_addr 0x10..0x13, ack low -> done, words_read=4.
REQ-035 Early stop: enable dropped after 2 rd_en -> ENDING, words_read=2, done after ack_read low.
REQ-036 Timeout: TIMEOUT=5, ack never asserted -> rq_read high 5 cycles, timeout_err one pulse, back to IDLE, no rd_en.
REQ-037 Wrap: ADDR_WIDTH=4, base_addr=0xE, BURST_LEN=4 -> rd_addr sequence 0xE,0xF,0x0,0x1.
REQ-038 Async reset mid-burst after 2 rd_en -> all outputs 0 before next edge, IDLE, no done.
REQ-039 Simultaneous ack_read and enable-low in REQUESTING -> READING one cycle, ENDING, words_read=0, done after ack low.
